block_mem_responder: RTL and testbench
======================================

// Module: block_mem_responder
// PURPOSE
//  Memory-side responder for the cache<->memory block interface, serving the mem_read/mem_write/
//  mem_address/mem_writedata/mem_readdata/mem_busywait handshake driven by dcache or icache.
//  Holds DEPTH blocks of BLOCK_BITS each, models a fixed multi-cycle access latency with a counter
//  FSM, and holds BUSYWAIT high until the access completes. Replaces fixed-delay memory models
//  with one parameterised, synthesizable, cycle-exact responder.
// PARAMETERS
//  BLOCK_BITS  128  width of one cache block (4 x 32-bit words)
//  ADDR_BITS   6    block address width; DEPTH = 2**ADDR_BITS blocks
//  LATENCY     40   cycles from request acceptance to data ready; legal range 1..255
// PORTS
//  CLK        in   1           system clock, all state changes on posedge
//  RESET      in   1           asynchronous, active-low reset
//  READ       in   1           block read request from cache
//  WRITE      in   1           block write request from cache
//  ADDRESS    in   ADDR_BITS   block address
//  WRITEDATA  in   BLOCK_BITS  block to write
//  READDATA   out  BLOCK_BITS  block read result, registered
//  BUSYWAIT   out  1           responder busy; requester must hold or stall while high
// BEHAVIOUR
//  - Reset (RESET=0, async): state=IDLE, cnt=0, READDATA=0, BUSYWAIT=0. Array contents are
//    preserved (see CONFIGURATION).
//  - Reset mid-access aborts the access: no array write occurs; state=IDLE.
//  - FSM states:
//    IDLE: BUSYWAIT = READ|WRITE (combinational; requester stalls in the request cycle).
//          At a posedge with READ|WRITE: latch op, ADDRESS and WRITEDATA; cnt <= LATENCY-1;
//          go to BUSY.
//    BUSY: BUSYWAIT=1. Each posedge with cnt!=0: cnt <= cnt-1.
//          At a posedge with cnt==0: perform the access. Read: READDATA <= mem[addr_q].
//          Write: mem[addr_q] <= wdata_q. Then go to DONE.
//    DONE: BUSYWAIT=0 and READDATA valid for the whole cycle. READ/WRITE are ignored in this
//          cycle. Next posedge goes to IDLE.
//  - Timing: a request accepted at posedge t0 completes at posedge t0+LATENCY. BUSYWAIT falls
//    after that edge. The requester samples the data/ack at posedge t0+LATENCY+1.
//  - Accepted request is fixed: changes on ADDRESS/WRITEDATA/READ/WRITE while in BUSY have no
//    effect.
//  - READ and WRITE both high in IDLE: treated as write, read dropped; READDATA unchanged.
//  - READDATA holds its last read value through writes and idle cycles.
//  - Back-to-back: a request held through DONE is re-accepted at the first IDLE posedge. Minimum
//    spacing between accepts is LATENCY+2 cycles.
//  - All 2**ADDR_BITS addresses are valid; no wrap or out-of-range case exists.
//  - Counter width 8 bits; LATENCY=1 gives cnt=0 on entry, so the access occurs at the next
//    posedge.
// CONFIGURATION
//  - BLOCK_CLEAR_ON_RESET_EN defined: the RESET assertion also clears every block of mem to 0,
//    asynchronously with the rest of reset.
//  - Not defined: mem is untouched by reset. Contents read back as X until first written.
//    Bench preloads through hierarchical writes only.
// TESTING  (LATENCY=5 unless stated)
//  1. Reset then idle: RESET=0 for 2 cycles then release, READ=WRITE=0 -> BUSYWAIT=0,
//     READDATA=0, state IDLE throughout.
//  2. Write then read: WRITE, ADDRESS=6'h0A, WRITEDATA=128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D
//     -> BUSYWAIT high 6 cycles, falls after posedge t0+5. Then READ addr 0x0A ->
//     READDATA=same value in DONE cycle.
//  3. Latched request: READ addr 0x3F with ADDRESS toggled to 0x00 during BUSY ->
//     READDATA=mem[0x3F]; mem[0x00] untouched.
//  4. Reset mid-write: WRITE addr 0x05 data all-ones, RESET=0 at cycle 3 of BUSY ->
//     BUSYWAIT=0 immediately; later read of 0x05 returns the prior value (0 with the macro
//     defined).
//  5. Simultaneous READ&WRITE addr 0x11 data 128'h1 -> mem[0x11]=1; READDATA unchanged;
//     a later read of 0x11 returns 128'h1.
//  6. LATENCY=1 back-to-back reads 0x01 then 0x02 held continuously -> accepts exactly 3 cycles
//     apart; each DONE shows the correct block.

Source files
------------

// File: rtl/block_mem_responder.sv
// Block memory responder for the cache<->memory handshake, with a fixed multi-cycle access latency.
// Optional macro BLOCK_CLEAR_ON_RESET_EN: reset also clears every stored block to zero.
module block_mem_responder #(
   parameter int unsigned BLOCK_BITS = 128,
   parameter int unsigned ADDR_BITS  = 6,
   parameter int unsigned LATENCY    = 40
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  READ,
   input  logic                  WRITE,
   input  logic [ADDR_BITS-1:0]  ADDRESS,
   input  logic [BLOCK_BITS-1:0] WRITEDATA,
   output logic [BLOCK_BITS-1:0] READDATA,
   output logic                  BUSYWAIT
);

   localparam int unsigned DEPTH    = 1 << ADDR_BITS;
   localparam int unsigned CNT_BITS = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                state;
   logic [CNT_BITS-1:0]   cnt;
   logic                  op_write;
   logic [ADDR_BITS-1:0]  addr_q;
   logic [BLOCK_BITS-1:0] wdata_q;
   logic [BLOCK_BITS-1:0] mem [DEPTH];
   logic                  access;
   logic                  mem_we;

   assign access = (state == BUSY) && (cnt == '0);
   assign mem_we = access && op_write;

   // The requester must stall in its request cycle, so IDLE reflects the request directly.
   assign BUSYWAIT = (state == IDLE) ? (READ | WRITE) : (state == BUSY);

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state    <= IDLE;
         cnt      <= '0;
         READDATA <= '0;
         op_write <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (READ | WRITE) begin
                  op_write <= WRITE;
                  addr_q   <= ADDRESS;
                  wdata_q  <= WRITEDATA;
                  cnt      <= CNT_BITS'(LATENCY - 1);
                  state    <= BUSY;
               end
            end
            BUSY: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_BITS'(1);
               end else begin
                  if (!op_write) READDATA <= mem[addr_q];
                  state <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Storage array; an aborted access never writes because reset forces the FSM out of BUSY.
`ifdef BLOCK_CLEAR_ON_RESET_EN
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[ADDR_BITS'(i)] <= '0;
      end else if (mem_we) begin
         mem[addr_q] <= wdata_q;
      end
   end
`else
   always_ff @(posedge CLK) begin
      if (mem_we) mem[addr_q] <= wdata_q;
   end
`endif

endmodule

// File: tb/tb_block_mem_responder.sv
// Self-checking bench for block_mem_responder: table of transactions plus latency, abort and back-to-back sequences.
module tb_block_mem_responder;

   localparam int unsigned BB  = 128;
   localparam int unsigned AB  = 6;
   localparam int unsigned LAT = 5;

   logic CLK   = 1'b0;
   logic RESET = 1'b0;
   always #5 CLK = ~CLK;

   logic          rd0, wr0, bw0;
   logic [AB-1:0] a0;
   logic [BB-1:0] wd0, q0;
   logic          rd1, wr1, bw1;
   logic [AB-1:0] a1;
   logic [BB-1:0] wd1, q1;

   block_mem_responder #(.BLOCK_BITS(BB), .ADDR_BITS(AB), .LATENCY(LAT)) u_dut (
      .CLK(CLK), .RESET(RESET), .READ(rd0), .WRITE(wr0), .ADDRESS(a0),
      .WRITEDATA(wd0), .READDATA(q0), .BUSYWAIT(bw0)
   );

   block_mem_responder #(.BLOCK_BITS(BB), .ADDR_BITS(AB), .LATENCY(1)) u_dut1 (
      .CLK(CLK), .RESET(RESET), .READ(rd1), .WRITE(wr1), .ADDRESS(a1),
      .WRITEDATA(wd1), .READDATA(q1), .BUSYWAIT(bw1)
   );

   int checks   = 0;
   int failures = 0;

   logic [BB-1:0] model [int];
   logic [BB-1:0] last_rd = '0;
   logic [BB-1:0] exp_q [$];

   typedef struct {
      logic          rd;
      logic          wr;
      logic [AB-1:0] addr;
      logic [BB-1:0] data;
      logic [BB-1:0] exp;
   } vec_t;
   vec_t vecs [9];

   localparam logic [BB-1:0] D0A = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
   localparam logic [BB-1:0] D3F = 128'h3F3F3F3F_00000000_11111111_3F3F3F3F;
   localparam logic [BB-1:0] D00 = 128'h0000AAAA_5555AAAA_0000AAAA_5555AAAA;
   localparam logic [BB-1:0] D05 = 128'h12345678_9ABCDEF0_0F1E2D3C_4B5A6978;
   localparam logic [BB-1:0] D11 = 128'h1;
   localparam logic [BB-1:0] A1  = 128'hA1A1A1A1_00000001_A1A1A1A1_00000001;
   localparam logic [BB-1:0] A2  = 128'hA2A2A2A2_00000002_A2A2A2A2_00000002;

   task automatic check(input string name, input logic [BB-1:0] act, input logic [BB-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference memory: both-high requests behave as writes; writes leave the read register alone.
   function automatic logic [BB-1:0] predict(input logic rd, input logic wr,
                                             input logic [AB-1:0] a, input logic [BB-1:0] d);
      if (wr) model[int'(a)] = d;
      else if (rd) last_rd = model[int'(a)];
      return last_rd;
   endfunction

   task automatic req0(input logic rd, input logic wr, input logic [AB-1:0] a,
                       input logic [BB-1:0] d, input bit toggle, input logic [BB-1:0] exp,
                       input string name);
      int busy;
      int guard;
      @(negedge CLK);
      rd0 = rd; wr0 = wr; a0 = a; wd0 = d;
      exp_q.push_back(exp);
      #1;
      busy  = bw0 ? 1 : 0;
      guard = 0;
      do begin
         @(posedge CLK); #1;
         guard++;
         if (toggle) begin a0 = '0; wd0 = ~d; end
         if (bw0) busy++;
      end while (bw0 && guard < 200);
      rd0 = 1'b0; wr0 = 1'b0;
      check($sformatf("%s busy_cycles", name), BB'(busy), BB'(LAT + 1));
      check($sformatf("%s rdata", name), q0, exp_q.pop_front());
      @(posedge CLK); #1;
   endtask

   task automatic write1(input logic [AB-1:0] a, input logic [BB-1:0] d, input string name);
      int busy;
      int guard;
      @(negedge CLK);
      wr1 = 1'b1; a1 = a; wd1 = d;
      #1;
      busy  = bw1 ? 1 : 0;
      guard = 0;
      do begin
         @(posedge CLK); #1;
         guard++;
         if (bw1) busy++;
      end while (bw1 && guard < 200);
      wr1 = 1'b0;
      check($sformatf("%s busy_cycles", name), BB'(busy), BB'(2));
      @(posedge CLK); #1;
   endtask

   initial begin
      int cyc;
      int first;
      int done_seen;

      rd0 = 1'b0; wr0 = 1'b0; a0 = '0; wd0 = '0;
      rd1 = 1'b0; wr1 = 1'b0; a1 = '0; wd1 = '0;

      vecs[0] = '{1'b0, 1'b1, 6'h0A, D0A, '0};
      vecs[1] = '{1'b1, 1'b0, 6'h0A, '0,  D0A};
      vecs[2] = '{1'b0, 1'b1, 6'h3F, D3F, D0A};
      vecs[3] = '{1'b0, 1'b1, 6'h00, D00, D0A};
      vecs[4] = '{1'b1, 1'b0, 6'h00, '0,  D00};
      vecs[5] = '{1'b1, 1'b1, 6'h11, D11, D00};
      vecs[6] = '{1'b1, 1'b0, 6'h11, '0,  D11};
      vecs[7] = '{1'b0, 1'b1, 6'h05, D05, D11};
      vecs[8] = '{1'b1, 1'b0, 6'h3F, '0,  D3F};

      // Reset then idle
      repeat (2) @(negedge CLK);
      check("reset busywait", BB'(bw0), '0);
      check("reset readdata", q0, '0);
      RESET = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         check($sformatf("idle%0d busywait", i), BB'(bw0), '0);
         check($sformatf("idle%0d readdata", i), q0, '0);
      end

      for (int i = 0; i < 9; i++) begin
         void'(predict(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data));
         req0(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, 1'b0, vecs[i].exp,
              $sformatf("vec%0d", i));
      end

      // Request fields latched at acceptance; later ADDRESS changes ignored
      req0(1'b1, 1'b0, 6'h3F, '0, 1'b1, predict(1'b1, 1'b0, 6'h3F, '0), "latched_3f");
      req0(1'b1, 1'b0, 6'h00, '0, 1'b0, predict(1'b1, 1'b0, 6'h00, '0), "untouched_00");

      // Reset in the middle of a write aborts it
      @(negedge CLK);
      wr0 = 1'b1; a0 = 6'h05; wd0 = '1;
      repeat (4) @(posedge CLK);
      #1;
      RESET = 1'b0; wr0 = 1'b0;
      #1;
      check("abort busywait", BB'(bw0), '0);
      check("abort readdata", q0, '0);
      repeat (2) @(negedge CLK);
      RESET = 1'b1;
      last_rd = '0;
`ifdef BLOCK_CLEAR_ON_RESET_EN
      foreach (model[k]) model[k] = '0;
`endif
      req0(1'b1, 1'b0, 6'h05, '0, 1'b0, predict(1'b1, 1'b0, 6'h05, '0), "after_abort_05");
      req0(1'b1, 1'b0, 6'h11, '0, 1'b0, predict(1'b1, 1'b0, 6'h11, '0), "after_abort_11");

      // LATENCY=1 instance: back-to-back held reads
      write1(6'h01, A1, "lat1_wr01");
      write1(6'h02, A2, "lat1_wr02");
      @(negedge CLK);
      rd1 = 1'b1; a1 = 6'h01;
      cyc = 0; first = 0; done_seen = 0;
      while (done_seen < 2 && cyc < 50) begin
         @(posedge CLK); #1;
         cyc++;
         if (!bw1) begin
            if (done_seen == 0) begin
               check("b2b first rdata", q1, A1);
               first = cyc;
               a1 = 6'h02;
            end else begin
               check("b2b second rdata", q1, A2);
               check("b2b spacing", BB'(cyc - first), BB'(3));
            end
            done_seen++;
         end
      end
      rd1 = 1'b0;
      check("b2b done count", BB'(done_seen), BB'(2));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
